// File: rtl/gift_pkg.sv
// Shared definitions for the GIFT-128 round controller: defaults, FSM encoding,
// and the key-schedule and round-constant next-state functions.
package gift_pkg;

  localparam int         ROUNDS_DEFAULT  = 40;
  localparam logic [5:0] RC_INIT_DEFAULT = 6'h01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [15:0] ror16(input logic [15:0] x, input int unsigned n);
    ror16 = (x >> n) | (x << (16 - n));
  endfunction

  // k7'=k1>>>2, k6'=k0>>>12, k5'..k0' = k7..k2 (k7 is the most significant word)
  function automatic logic [127:0] key_update(input logic [127:0] key);
    key_update = {ror16(key[31:16], 2), ror16(key[15:0], 12), key[127:32]};
  endfunction

  function automatic logic [5:0] rc_next(input logic [5:0] rc);
    rc_next = {rc[4:0], rc[5] ^ rc[4] ^ 1'b1};
  endfunction

endpackage

// File: rtl/gift_key_sched.sv
// GIFT-128 key register: loads the master key, advances one round per update,
// and exposes the U/V round-key halves of the current key state.
module gift_key_sched
  import gift_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         update,
  input  logic [127:0] key_in,
  output logic [31:0]  round_key_u,
  output logic [31:0]  round_key_v
);

  logic [127:0] key_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q <= '0;
    end else if (load) begin
      key_q <= key_in;
    end else if (update) begin
      key_q <= key_update(key_q);
    end
  end

  assign round_key_u = key_q[95:64];
  assign round_key_v = key_q[31:0];

endmodule

// File: rtl/gift_round_ctrl.sv
// Round sequencer for the GIFT-128 datapath: loads the block, issues one
// internal write per round with its key halves and constant, then pulses done.
//
// state | meaning
// IDLE  | waiting for start; start drives the external write combinationally
// RUN   | one round per cycle, internal write asserted
// DONE  | one-cycle completion pulse, state register holds the ciphertext
module gift_round_ctrl
  import gift_pkg::*;
#(
  parameter int         ROUNDS  = ROUNDS_DEFAULT,
  parameter logic [5:0] RC_INIT = RC_INIT_DEFAULT
) (
  input  logic         inClk,
  input  logic         inRstN,
  input  logic         inStart,
  input  logic [127:0] inPlaintext,
  input  logic [127:0] inKey,
  output logic         outExtWr,
  output logic [127:0] outExtData,
  output logic         outIntWr,
  output logic [31:0]  outRoundKeyU,
  output logic [31:0]  outRoundKeyV,
  output logic [5:0]   outRoundConst,
  output logic         outBusy,
  output logic         outDone
);

  // one extra count of headroom so the increment on the last round never wraps
  localparam int            CW   = $clog2(ROUNDS + 1);
  localparam logic [CW-1:0] LAST = CW'(ROUNDS - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [5:0]    rc;
  logic          accept;

  assign accept = (state == IDLE) && inStart;

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (inStart) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    outExtWr = 1'b0;
    outIntWr = 1'b0;
    outBusy  = 1'b0;
    outDone  = 1'b0;
    case (state)
      IDLE:    outExtWr = inStart;
      RUN: begin
        outIntWr = 1'b1;
        outBusy  = 1'b1;
      end
      DONE:    outDone = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge inClk or negedge inRstN) begin
    if (!inRstN) begin
      cnt <= '0;
      rc  <= '0;
    end else if (accept) begin
      cnt <= '0;
      rc  <= RC_INIT;
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      rc  <= rc_next(rc);
    end
  end

  gift_key_sched u_key_sched (
    .clk         (inClk),
    .rst_n       (inRstN),
    .load        (accept),
    .update      (state == RUN),
    .key_in      (inKey),
    .round_key_u (outRoundKeyU),
    .round_key_v (outRoundKeyV)
  );

  assign outExtData    = inPlaintext;
  assign outRoundConst = rc;

endmodule

// File: tb/tb_gift_round_ctrl.sv
// Directed bench for gift_round_ctrl: reset, key schedule, constant sequence,
// strobe timing, start-ignore windows, back-to-back start and mid-run reset.
module tb_gift_round_ctrl;

  logic         inClk = 1'b0;
  logic         inRstN = 1'b0;
  logic         inStart = 1'b0;
  logic [127:0] inPlaintext = '0;
  logic [127:0] inKey = '0;
  logic         outExtWr;
  logic [127:0] outExtData;
  logic         outIntWr;
  logic [31:0]  outRoundKeyU;
  logic [31:0]  outRoundKeyV;
  logic [5:0]   outRoundConst;
  logic         outBusy;
  logic         outDone;

  int total = 0;
  int bad   = 0;

  logic [5:0] rc_tab [40] = '{
    6'h01, 6'h03, 6'h07, 6'h0F, 6'h1F, 6'h3E, 6'h3D, 6'h3B, 6'h37, 6'h2F,
    6'h1E, 6'h3C, 6'h39, 6'h33, 6'h27, 6'h0E, 6'h1D, 6'h3A, 6'h35, 6'h2B,
    6'h16, 6'h2C, 6'h18, 6'h30, 6'h21, 6'h02, 6'h05, 6'h0B, 6'h17, 6'h2E,
    6'h1C, 6'h38, 6'h31, 6'h23, 6'h06, 6'h0D, 6'h1B, 6'h36, 6'h2D, 6'h1A
  };

  gift_round_ctrl dut (
    .inClk         (inClk),
    .inRstN        (inRstN),
    .inStart       (inStart),
    .inPlaintext   (inPlaintext),
    .inKey         (inKey),
    .outExtWr      (outExtWr),
    .outExtData    (outExtData),
    .outIntWr      (outIntWr),
    .outRoundKeyU  (outRoundKeyU),
    .outRoundKeyV  (outRoundKeyV),
    .outRoundConst (outRoundConst),
    .outBusy       (outBusy),
    .outDone       (outDone)
  );

  always #5 inClk = ~inClk;

  task automatic tick();
    @(negedge inClk);
  endtask

  task automatic test_reset();
    logic [5:0] flags;
    tick();
    flags = {outExtWr, outIntWr, outBusy, outDone, 2'b00};
    total++;
    if (flags !== 6'b0) begin
      bad++;
      $display("FAIL reset_strobes got=%b want=000000", flags);
    end
    total++;
    if ({outRoundKeyU, outRoundKeyV, outRoundConst} !== 70'd0) begin
      bad++;
      $display("FAIL reset_keys got=%h/%h/%h want=0", outRoundKeyU, outRoundKeyV, outRoundConst);
    end
    inRstN = 1'b1;
    tick();
    total++;
    if (outBusy !== 1'b0 || outExtWr !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_idle busy=%b extwr=%b want=0,0", outBusy, outExtWr);
    end
  endtask

  task automatic test_key_schedule();
    inKey       = 128'h000102030405060708090a0b0c0d0e0f;
    inPlaintext = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    inStart     = 1'b1;
    #1;
    total++;
    if (outExtWr !== 1'b1 || outIntWr !== 1'b0) begin
      bad++;
      $display("FAIL start_extwr got=%b/%b want=1/0", outExtWr, outIntWr);
    end
    total++;
    if (outExtData !== 128'hdeadbeef_01234567_89abcdef_cafef00d) begin
      bad++;
      $display("FAIL start_extdata got=%h", outExtData);
    end
    tick();
    inStart = 1'b0;
    total++;
    if (outRoundKeyU !== 32'h04050607 || outRoundKeyV !== 32'h0c0d0e0f || outRoundConst !== 6'h01) begin
      bad++;
      $display("FAIL round1 got=%h/%h/%h want=04050607/0c0d0e0f/01", outRoundKeyU, outRoundKeyV, outRoundConst);
    end
    total++;
    if (outIntWr !== 1'b1 || outBusy !== 1'b1 || outExtWr !== 1'b0) begin
      bad++;
      $display("FAIL round1_strobes got=%b%b%b want=110", outIntWr, outBusy, outExtWr);
    end
    tick();
    total++;
    if (outRoundKeyU !== 32'h00010203 || outRoundKeyV !== 32'h08090a0b || outRoundConst !== 6'h03) begin
      bad++;
      $display("FAIL round2 got=%h/%h/%h want=00010203/08090a0b/03", outRoundKeyU, outRoundKeyV, outRoundConst);
    end
    tick();
    // round 3 U exposes the round-2 rotated words k7'=4303, k6'=e0f0
    total++;
    if (outRoundKeyU !== 32'h4303e0f0 || outRoundKeyV !== 32'h04050607) begin
      bad++;
      $display("FAIL round3 got=%h/%h want=4303e0f0/04050607", outRoundKeyU, outRoundKeyV);
    end
    for (int i = 0; i < 50 && !outDone; i++) tick();
    tick();
  endtask

  task automatic test_const_timing();
    int ext_cnt;
    int int_cnt;
    int rc_bad;
    inKey   = 128'h0;
    inStart = 1'b1;
    #1;
    ext_cnt = outExtWr ? 1 : 0;
    int_cnt = 0;
    rc_bad  = 0;
    tick();
    inStart = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (outExtWr) ext_cnt++;
      if (outIntWr) int_cnt++;
      if (outRoundConst !== rc_tab[i]) begin
        rc_bad++;
        $display("FAIL const_seq idx=%0d got=%h want=%h", i, outRoundConst, rc_tab[i]);
      end
      if (outDone) $display("FAIL early_done cycle=%0d got=1 want=0", i + 1);
      if (outDone) rc_bad++;
      tick();
    end
    total++;
    if (rc_bad != 0) bad++;
    total++;
    if (ext_cnt != 1 || int_cnt != 40) begin
      bad++;
      $display("FAIL strobe_count ext=%0d int=%0d want=1/40", ext_cnt, int_cnt);
    end
    total++;
    if (outDone !== 1'b1 || outBusy !== 1'b0 || outIntWr !== 1'b0 || outExtWr !== 1'b0) begin
      bad++;
      $display("FAIL done_cycle41 done=%b busy=%b int=%b ext=%b want=1000", outDone, outBusy, outIntWr, outExtWr);
    end
    tick();
    total++;
    if (outDone !== 1'b0 || outRoundConst !== 6'h34) begin
      bad++;
      $display("FAIL done_pulse_len done=%b const=%h want=0/34", outDone, outRoundConst);
    end
  endtask

  task automatic test_ignore();
    int cyc;
    int int_cnt;
    int stray;
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    cyc = 1;
    int_cnt = 0;
    stray = 0;
    while (!outDone && cyc < 60) begin
      if (cyc == 10) begin
        inStart = 1'b1;
        #1;
        if (outExtWr !== 1'b0) stray++;
      end
      if (outIntWr) int_cnt++;
      tick();
      inStart = 1'b0;
      cyc++;
    end
    total++;
    if (cyc != 41 || int_cnt != 40 || stray != 0) begin
      bad++;
      $display("FAIL ignore_run done_cycle=%0d int=%0d stray=%0d want=41/40/0", cyc, int_cnt, stray);
    end
    inStart = 1'b1;
    #1;
    total++;
    if (outExtWr !== 1'b0 || outDone !== 1'b1) begin
      bad++;
      $display("FAIL ignore_done ext=%b done=%b want=0/1", outExtWr, outDone);
    end
    tick();
    inStart = 1'b0;
    #1;
    tick();
    total++;
    if (outBusy !== 1'b0 || outIntWr !== 1'b0) begin
      bad++;
      $display("FAIL ignore_no_load busy=%b int=%b want=0/0", outBusy, outIntWr);
    end
  endtask

  task automatic test_back_to_back();
    inStart = 1'b1;
    tick();
    inStart = 1'b0;
    for (int i = 0; i < 60 && !outDone; i++) tick();
    inKey   = 128'hffeeddccbbaa99887766554433221100;
    inStart = 1'b1;
    #1;
    total++;
    if (outExtWr !== 1'b0 || outDone !== 1'b1) begin
      bad++;
      $display("FAIL b2b_done_cycle ext=%b done=%b want=0/1", outExtWr, outDone);
    end
    tick();
    total++;
    if (outExtWr !== 1'b1 || outBusy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_load ext=%b busy=%b want=1/0", outExtWr, outBusy);
    end
    tick();
    inStart = 1'b0;
    total++;
    if (outBusy !== 1'b1 || outRoundConst !== 6'h01 || outRoundKeyU !== 32'hbbaa9988 || outRoundKeyV !== 32'h33221100) begin
      bad++;
      $display("FAIL b2b_round1 busy=%b const=%h u=%h v=%h", outBusy, outRoundConst, outRoundKeyU, outRoundKeyV);
    end
  endtask

  // continues the block started by test_back_to_back, now in round 1
  task automatic test_reset_mid_run();
    for (int i = 1; i < 17; i++) tick();
    total++;
    if (outRoundConst !== rc_tab[16] || outBusy !== 1'b1) begin
      bad++;
      $display("FAIL mid_run_r17 const=%h busy=%b want=%h/1", outRoundConst, outBusy, rc_tab[16]);
    end
    #2;
    inRstN = 1'b0;
    #1;
    total++;
    if ({outExtWr, outIntWr, outBusy, outDone} !== 4'b0 || {outRoundKeyU, outRoundKeyV, outRoundConst} !== 70'd0) begin
      bad++;
      $display("FAIL mid_run_reset strobes=%b%b%b%b u=%h v=%h c=%h want=0", outExtWr, outIntWr, outBusy, outDone, outRoundKeyU, outRoundKeyV, outRoundConst);
    end
    tick();
    tick();
    inRstN = 1'b1;
    tick();
    tick();
    total++;
    if (outBusy !== 1'b0 || outIntWr !== 1'b0 || outDone !== 1'b0) begin
      bad++;
      $display("FAIL after_reset_idle busy=%b int=%b done=%b want=000", outBusy, outIntWr, outDone);
    end
  endtask

  initial begin
    test_reset();
    test_key_schedule();
    test_const_timing();
    test_ignore();
    test_back_to_back();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  always @(negedge inClk) begin
    if (inRstN && outExtWr && outIntWr) begin
      bad++;
      $display("FAIL strobe_overlap ext=1 int=1 want=exclusive");
    end
  end

endmodule

// File: doc/gift_round_ctrl.md
Name: gift_round_ctrl

Overview:
- Iterative control and key-schedule stage for the GIFT-128 encryption datapath. It sits directly upstream of the 128-bit round state register.
- It drives the register's external-write and internal-write strobes and external load data.
- It supplies the per-round key halves (U, V) and the 6-bit round constant to the combinational round function.
- It runs one round per clock for 40 rounds, then signals completion.

Parameters:
- ROUNDS, 40, number of rounds executed per block.
- RC_INIT, 6'h01, round constant used in round 1.

Ports:
- inClk  input  1  clock; all state updates on rising edge.
- inRstN  input  1  asynchronous, active-low reset.
- inStart  input  1  start request; sampled only in IDLE.
- inPlaintext  input  128  block loaded into the state register on start.
- inKey  input  128  master key, captured on start.
- outExtWr  output  1  external-write strobe to the state register.
- outExtData  output  128  load data for the state register; equals inPlaintext.
- outIntWr  output  1  internal-write strobe (accept round-function output).
- outRoundKeyU  output  32  round key U = k5||k4 of the current key state.
- outRoundKeyV  output  32  round key V = k1||k0 of the current key state.
- outRoundConst  output  6  current round constant c5..c0.
- outBusy  output  1  high while a block is being processed.
- outDone  output  1  one-cycle pulse; the state register now holds the ciphertext.

Behaviour:
- Reset: async on inRstN=0.
  - State returns to IDLE.
  - Key register, round counter and constant register clear to 0.
  - outExtWr, outIntWr, outBusy and outDone are all 0.
  - outRoundKeyU, outRoundKeyV and outRoundConst are 0.
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - outExtWr = inStart, combinationally.
  - On an edge with inStart=1: key register <= inKey, constant <= RC_INIT, counter <= 0, next state RUN.
  - With inStart=0, the machine stays in IDLE.
- RUN:
  - outIntWr=1 and outBusy=1 on every cycle.
  - Round keys and constant reflect the round being computed. Round r+1 uses counter value r.
  - Each edge updates the key register: k7'=k1>>>2, k6'=k0>>>12, (k5'..k0')=(k7..k2), where k7=key[127:112], 16-bit words and >>> is rotate right.
  - Each edge updates the constant: c' = {c4,c3,c2,c1,c0, c5^c4^1}.
  - Each edge increments the counter.
  - When counter = ROUNDS-1 at an edge, next state is DONE.
  - Exactly ROUNDS internal writes occur per block.
- DONE:
  - outDone=1 and outBusy=0 for exactly one cycle; the state register output is the ciphertext.
  - Next state is IDLE.
  - Key, counter and constant hold their values; no write strobe is asserted.
- Latency: start accepted at edge 0, ciphertext valid after edge ROUNDS (40), outDone high in the following cycle. Start-to-done is 41 cycles.
- Boundaries:
  - inStart in RUN or DONE is ignored: outExtWr stays 0 and no state change occurs.
  - inStart high in the same cycle as a DONE->IDLE transition is not accepted. It is accepted on the next IDLE cycle if still high.
  - Back-to-back blocks are possible: at minimum one IDLE cycle between outDone and the next load.
  - Reset mid-RUN aborts immediately. The state register is not written by this block after reset.
  - outExtWr and outIntWr are never high in the same cycle.
  - The counter is wide enough for ROUNDS (6 bits at default) and never wraps within a block.

Decomposition:
- Shared package gift_pkg holds:
  - ROUNDS_DEFAULT = 40 and RC_INIT_DEFAULT = 6'h01;
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the key-update function and the constant-LFSR next-state function.
- One natural sub-module: gift_key_sched.
  - Contains the 128-bit key register, load/update controls, and the U/V output extraction.
- FSM, counter and constant register stay in gift_round_ctrl.

Test Plan:
- Reset: assert inRstN=0 mid-RUN (round 17) -> all outputs 0 within the same cycle. After release, state is IDLE and outBusy=0.
- Start with inKey=0x000102030405060708090a0b0c0d0e0f:
  - start cycle -> outExtWr=1 with outExtData=inPlaintext;
  - round 1 -> U=0x04050607, V=0x0c0d0e0f, const=0x01;
  - round 2 -> U=0x00010203, V=0x08090a0b, key words k7=0x4303 and k6=0xe0f0.
- Constant sequence: capture outRoundConst over the 40 outIntWr cycles -> 01,03,07,0F,1F,3E,3D,3B,37,2F,1E,3C,39,33,27,0E,1D,3A,35,2B,16,2C,18,30,21,02,05,0B,17,2E,1C,38,31,23,06,0D,1B,36,2D,1A.
- Timing: count strobes from the start edge -> exactly 1 outExtWr, then exactly 40 outIntWr, then outDone high for one cycle at cycle 41 and outBusy low.
- Ignore: pulse inStart during round 10 and during the DONE cycle -> no outExtWr, round count unaffected. Holding inStart high through the DONE cycle -> new load on the next IDLE cycle.
- Integration: connect to the round function and state register with key=0, plaintext=0 -> register output at outDone matches the GIFT-128 golden C model ciphertext. Then run 100 random key/plaintext pairs against the same model.
